l2_word_responder: RTL and testbench
====================================

L2_WORD_RESPONDER -- requirements
Module: l2_word_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width; any value other than 32 SHALL raise an elaboration $error.
REQ-002 SHALL have parameter MEM_SIZE, default 4096, meaning backing store size in bytes; it SHALL be a power of two and divisible by 4, else $error.
REQ-003 SHALL have parameter ACCESS_LATENCY, default 4, meaning BUSY cycles per access; a value below 1 SHALL raise $error.
REQ-004 SHALL have port clk, input, width 1: the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, width 1: the requester has a request pending.
REQ-007 SHALL have port req_write, input, width 1: 1 means store word, 0 means fetch word.
REQ-008 SHALL have port req_address, input, width XLEN: byte address, where bits [1:0] are ignored.
REQ-009 SHALL have port req_word_to_store, input, width XLEN: store data.
REQ-010 SHALL have port fetched_word, output, width XLEN: read data.
REQ-011 SHALL have port req_fulfilled, output, width 1: one-cycle completion pulse.
REQ-012 SHALL have port busy, output, width 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL hold MEM_SIZE/4 words, addressed by word index req_address[$clog2(MEM_SIZE)-1:2]; higher address bits SHALL be ignored, so addresses wrap modulo MEM_SIZE.
REQ-014 SHALL implement three states: IDLE, BUSY and RESPOND.
REQ-015 IDLE with req_valid=1 at an edge SHALL capture req_write, the word index and req_word_to_store into internal registers, load the latency counter with ACCESS_LATENCY-1, and move to BUSY.
REQ-016 After capture, input changes SHALL NOT affect the in-flight transaction.
REQ-017 In BUSY, the counter SHALL be 0 before it moves to RESPOND; otherwise it SHALL decrement and remain in BUSY. BUSY SHALL last exactly ACCESS_LATENCY cycles.
REQ-018 RESPOND SHALL last exactly one cycle with req_fulfilled=1, then return to IDLE; req_fulfilled SHALL be 0 in every other state.
REQ-019 With an accept edge at the end of cycle T, req_fulfilled SHALL be high in cycle T+ACCESS_LATENCY+1.
REQ-020 On a read, fetched_word SHALL be registered on the BUSY->RESPOND edge with mem[captured index], SHALL be valid during RESPOND, and SHALL hold its value until the next read response.
REQ-021 On a write, mem[captured index] SHALL be updated on the RESPOND->IDLE edge with the full captured word; fetched_word SHALL be unchanged.
REQ-022 req_valid SHALL be ignored in BUSY and RESPOND.
REQ-023 If req_valid is still high in the IDLE cycle after RESPOND, a new transaction SHALL start, so the requester must drop req_valid on req_fulfilled; back-to-back transactions SHALL therefore be spaced ACCESS_LATENCY+2 cycles apart.
REQ-024 A read immediately following a write to the same index SHALL return the new data.
REQ-025 There SHALL be no byte or halfword granularity; every access SHALL be a full word.

Reset
REQ-026 Reset SHALL asynchronously force state IDLE, counter 0, fetched_word 0, req_fulfilled 0 and busy 0.
REQ-027 Reset during BUSY or RESPOND SHALL abort the transaction, and no memory write SHALL occur.
REQ-028 Memory contents SHALL NOT be cleared by reset; they are undefined until written.
REQ-029 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-030 Write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0040 -> each req_fulfilled arrives 5 cycles after accept (default latency) and fetched_word = 0xDEADBEEF.
REQ-031 Write 0x1234_5678 to 0x0000_1004 with MEM_SIZE=4096, then read 0x0000_0004 -> 0x1234_5678 (wrap); reading 0x0000_0006 also -> 0x1234_5678 (bits [1:0] ignored).
REQ-032 Hold req_valid high continuously for reads of index 0..7, each word preloaded with its index -> 8 pulses spaced 6 cycles apart, fetched_word 0..7 in order.
REQ-033 Accept a write of 0xAAAA_AAAA to 0x80 over a prior 0x5555_5555, change req_address and data during BUSY -> the 0x80 write completes with 0xAAAA_AAAA; the new address is not touched.
REQ-034 Assert reset in the 2nd BUSY cycle of a write of 0xFFFF_FFFF to 0x10 that previously held 0x0 -> busy=0, req_fulfilled=0 and fetched_word=0 immediately; a later read of 0x10 returns 0x0.
REQ-035 ACCESS_LATENCY=1, single read -> busy high for 2 cycles and req_fulfilled in cycle T+2.

Source files
------------

// File: rtl/l2_word_responder.sv
// l2_word_responder: single-port word memory behind a fixed-latency
// request/response handshake (IDLE -> BUSY x ACCESS_LATENCY -> RESPOND).
module l2_word_responder #(
    parameter int XLEN           = 32,
    parameter int MEM_SIZE       = 4096,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_address,
    input  logic [XLEN-1:0] req_word_to_store,
    output logic [XLEN-1:0] fetched_word,
    output logic            req_fulfilled,
    output logic            busy
);

    localparam int WORDS     = (MEM_SIZE >= 4) ? MEM_SIZE / 4 : 1;
    localparam int ADDR_BITS = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int IDX_W     = (ADDR_BITS > 2) ? ADDR_BITS - 2 : 1;
    localparam int CNT_W     = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LATENCY - 1);

    if (XLEN != 32) begin : g_bad_xlen
        $error("l2_word_responder: XLEN must be 32");
    end
    if ((MEM_SIZE < 4) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0) || ((MEM_SIZE % 4) != 0)) begin : g_bad_mem
        $error("l2_word_responder: MEM_SIZE must be a power of two divisible by 4");
    end
    if (ACCESS_LATENCY < 1) begin : g_bad_lat
        $error("l2_word_responder: ACCESS_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [XLEN-1:0]   fetched_q, fetched_d;
    logic              fulfilled_q, fulfilled_d;
    logic              busy_q, busy_d;

    logic [XLEN-1:0]   mem [WORDS];

    // Word index: drop the byte offset, then keep only bits that fit the store
    // so that addresses wrap modulo MEM_SIZE.
    logic [XLEN-1:0]   addr_word;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr_bits;

    assign addr_word        = req_address >> 2;
    assign req_idx          = addr_word[IDX_W-1:0] & IDX_MASK;
    assign unused_addr_bits = ^addr_word[XLEN-1:IDX_W];

    // Next-state logic: capture on accept, count down in BUSY, pulse in RESPOND.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        data_d      = data_q;
        fetched_d   = fetched_q;
        fulfilled_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    idx_d   = req_idx;
                    data_d  = req_word_to_store;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                    busy_d  = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESPOND;
                    fulfilled_d = 1'b1;
                    if (!wr_q) begin
                        fetched_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            fetched_q   <= '0;
            fulfilled_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            fetched_q   <= fetched_d;
            fulfilled_q <= fulfilled_d;
            busy_q      <= busy_d;
        end
    end

    // Captured request payload; only meaningful while a transaction is in flight.
    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        data_q <= data_d;
    end

    // Store commits on leaving RESPOND; reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk) begin
        if ((state_q == S_RESPOND) && wr_q) begin
            mem[idx_q] <= data_q;
        end
    end

    assign fetched_word  = fetched_q;
    assign req_fulfilled = fulfilled_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_l2_word_responder.sv
// Directed bench for l2_word_responder: default-latency instance plus an
// ACCESS_LATENCY=1 instance sharing clock and reset.
module tb_l2_word_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        v0, w0;
    logic [31:0] a0, d0;
    logic [31:0] f0;
    logic        ff0, b0;

    logic        v1, w1;
    logic [31:0] a1, d1;
    logic [31:0] f1;
    logic        ff1, b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l2_word_responder #(.XLEN(32), .MEM_SIZE(4096), .ACCESS_LATENCY(4)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0),
        .req_address(a0), .req_word_to_store(d0),
        .fetched_word(f0), .req_fulfilled(ff0), .busy(b0)
    );

    l2_word_responder #(.XLEN(32), .MEM_SIZE(4096), .ACCESS_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_write(w1),
        .req_address(a1), .req_word_to_store(d1),
        .fetched_word(f1), .req_fulfilled(ff1), .busy(b1)
    );

    // Drives one request at the current negedge and follows it until busy drops.
    // ful_cyc = negedges after the accept edge at which req_fulfilled was seen.
    task automatic run_txn(input int sel, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output int ful_cyc,
                           output int busy_cyc, output int pulses,
                           output logic [31:0] rdata);
        int   n;
        logic bz, fl;
        ful_cyc  = -1;
        busy_cyc = 0;
        pulses   = 0;
        rdata    = '0;
        if (sel == 0) begin
            v0 = 1'b1; w0 = wr; a0 = addr; d0 = data;
        end else begin
            v1 = 1'b1; w1 = wr; a1 = addr; d1 = data;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v0 = 1'b0;
            v1 = 1'b0;
            bz = (sel == 0) ? b0 : b1;
            fl = (sel == 0) ? ff0 : ff1;
            if (fl) begin
                pulses++;
                if (ful_cyc < 0) begin
                    ful_cyc = n;
                    rdata   = (sel == 0) ? f0 : f1;
                end
            end
            if (bz) busy_cyc++;
        end while (bz && n < 60);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v0 = 0; w0 = 0; a0 = 0; d0 = 0;
        v1 = 0; w1 = 0; a1 = 0; d1 = 0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (b0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy0: got %b expected 0", b0); end
        n_cmp++; if (ff0 !== 1'b0) begin n_bad++; $display("FAIL reset_fulfilled0: got %b expected 0", ff0); end
        n_cmp++; if (f0 !== 32'h0) begin n_bad++; $display("FAIL reset_fetched0: got %h expected 00000000", f0); end
        n_cmp++; if (b1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy1: got %b expected 0", b1); end
        n_cmp++; if (ff1 !== 1'b0) begin n_bad++; $display("FAIL reset_fulfilled1: got %b expected 0", ff1); end
        n_cmp++; if (f1 !== 32'h0) begin n_bad++; $display("FAIL reset_fetched1: got %h expected 00000000", f1); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int fc, bc, np;
        logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, fc, bc, np, rd);
        n_cmp++; if (fc !== 5) begin n_bad++; $display("FAIL wr40_latency: got %0d expected 5", fc); end
        n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL wr40_pulses: got %0d expected 1", np); end
        run_txn(0, 1'b0, 32'h0000_0040, 32'h0, fc, bc, np, rd);
        n_cmp++; if (fc !== 5) begin n_bad++; $display("FAIL rd40_latency: got %0d expected 5", fc); end
        n_cmp++; if (bc !== 5) begin n_bad++; $display("FAIL rd40_busy_cycles: got %0d expected 5", bc); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd40_data: got %h expected deadbeef", rd); end
        run_txn(0, 1'b1, 32'h0000_0044, 32'h1111_1111, fc, bc, np, rd);
        n_cmp++; if (f0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fetched_hold_after_write: got %h expected deadbeef", f0); end
    endtask

    task automatic test_wrap();
        int fc, bc, np;
        logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0000_1004, 32'h1234_5678, fc, bc, np, rd);
        run_txn(0, 1'b0, 32'h0000_0004, 32'h0, fc, bc, np, rd);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL wrap_rd4: got %h expected 12345678", rd); end
        run_txn(0, 1'b0, 32'h0000_0006, 32'h0, fc, bc, np, rd);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL wrap_rd6: got %h expected 12345678", rd); end
    endtask

    task automatic test_back_to_back();
        int fc, bc, np, k, n, last;
        logic [31:0] rd;
        for (int i = 0; i < 8; i++) begin
            run_txn(0, 1'b1, 32'(i * 4), 32'(i), fc, bc, np, rd);
        end
        v0 = 1'b1; w0 = 1'b0; a0 = 32'h0;
        k = 0; n = 0; last = 0;
        while (k < 8 && n < 200) begin
            @(negedge clk);
            n++;
            if (ff0) begin
                n_cmp++; if (f0 !== 32'(k)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, f0, 32'(k)); end
                if (k > 0) begin
                    n_cmp++; if ((n - last) !== 6) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d expected 6", k, n - last); end
                end
                last = n;
                k++;
                a0 = 32'(k * 4);
                if (k == 8) v0 = 1'b0;
            end
        end
        v0 = 1'b0;
        n_cmp++; if (k !== 8) begin n_bad++; $display("FAIL b2b_pulse_count: got %0d expected 8", k); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (b0 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got busy %b expected 0", b0); end
    endtask

    task automatic test_inflight();
        int fc, bc, np, n;
        logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0000_0080, 32'h5555_5555, fc, bc, np, rd);
        run_txn(0, 1'b1, 32'h0000_0100, 32'h0000_0000, fc, bc, np, rd);
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h0000_0080; d0 = 32'hAAAA_AAAA;
        @(negedge clk);
        v0 = 1'b0; w0 = 1'b1; a0 = 32'h0000_0100; d0 = 32'h1234_5678;
        @(negedge clk);
        w0 = 1'b0; a0 = 32'h0000_0104; d0 = 32'hFFFF_FFFF;
        n = 0;
        while (b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (b0 !== 1'b0) begin n_bad++; $display("FAIL inflight_done: got busy %b expected 0", b0); end
        run_txn(0, 1'b0, 32'h0000_0080, 32'h0, fc, bc, np, rd);
        n_cmp++; if (rd !== 32'hAAAA_AAAA) begin n_bad++; $display("FAIL inflight_rd80: got %h expected aaaaaaaa", rd); end
        run_txn(0, 1'b0, 32'h0000_0100, 32'h0, fc, bc, np, rd);
        n_cmp++; if (rd !== 32'h0000_0000) begin n_bad++; $display("FAIL inflight_rd100: got %h expected 00000000", rd); end
    endtask

    task automatic test_reset_abort();
        int fc, bc, np;
        logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0000_0010, 32'h0000_0000, fc, bc, np, rd);
        run_txn(0, 1'b0, 32'h0000_0080, 32'h0, fc, bc, np, rd);
        n_cmp++; if (f0 !== 32'hAAAA_AAAA) begin n_bad++; $display("FAIL abort_pre_fetched: got %h expected aaaaaaaa", f0); end
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h0000_0010; d0 = 32'hFFFF_FFFF;
        @(negedge clk);
        v0 = 1'b0;
        n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b expected 1", b0); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (b0 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", b0); end
        n_cmp++; if (ff0 !== 1'b0) begin n_bad++; $display("FAIL abort_fulfilled: got %b expected 0", ff0); end
        n_cmp++; if (f0 !== 32'h0) begin n_bad++; $display("FAIL abort_fetched: got %h expected 00000000", f0); end
        @(negedge clk);
        reset = 1'b0;
        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, fc, bc, np, rd);
        n_cmp++; if (fc !== 5) begin n_bad++; $display("FAIL first_accept_after_reset: got %0d expected 5", fc); end
        n_cmp++; if (rd !== 32'h0000_0000) begin n_bad++; $display("FAIL abort_rd10: got %h expected 00000000", rd); end
    endtask

    task automatic test_latency_one();
        int fc, bc, np;
        logic [31:0] rd;
        run_txn(1, 1'b1, 32'h0000_0008, 32'hCAFE_0001, fc, bc, np, rd);
        n_cmp++; if (fc !== 2) begin n_bad++; $display("FAIL lat1_wr_latency: got %0d expected 2", fc); end
        run_txn(1, 1'b0, 32'h0000_0008, 32'h0, fc, bc, np, rd);
        n_cmp++; if (fc !== 2) begin n_bad++; $display("FAIL lat1_rd_latency: got %0d expected 2", fc); end
        n_cmp++; if (bc !== 2) begin n_bad++; $display("FAIL lat1_busy_cycles: got %0d expected 2", bc); end
        n_cmp++; if (rd !== 32'hCAFE_0001) begin n_bad++; $display("FAIL lat1_rd_data: got %h expected cafe0001", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_back_to_back();
        test_inflight();
        test_reset_abort();
        test_latency_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
